// File: rtl/imem_responder_if.sv
// Fetch-side handshake between the fetch stage (master) and the instruction memory
// responder (slave).
interface imem_responder_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_flush;
    logic        o_ready;
    logic        o_valid;
    logic [31:0] o_instr;
    logic        o_fault;

    modport master (
        output i_req, i_addr, i_flush,
        input  o_ready, o_valid, o_instr, o_fault
    );

    modport slave (
        input  i_req, i_addr, i_flush,
        output o_ready, o_valid, o_instr, o_fault
    );
endinterface

// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts one fetch at a time, waits WAIT_CYCLES, then
// strobes the instruction word (or a NOP with o_fault) for one cycle.
module imem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
    input  logic                   clk,
    input  logic                   i_reset,
    imem_responder_if.slave        bus,
    input  logic                   i_load_we,
    input  logic [31:0]            i_load_addr,
    input  logic [31:0]            i_load_data
);
    localparam int unsigned IdxW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_addr;
    logic        r_valid;
    logic        r_fault;
    logic [31:0] r_instr;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic            w_accept;
    logic [31:0]     w_look_addr;
    logic [31:0]     w_word;
    logic            w_fault;
    logic [IdxW-1:0] w_idx;
    logic [31:0]     w_load_word;
    logic            w_load_ok;

    assign bus.o_ready = (r_state != StWait);
    assign bus.o_valid = r_valid;
    assign bus.o_instr = r_instr;
    assign bus.o_fault = r_fault;

    assign w_accept = bus.o_ready & bus.i_req & ~bus.i_flush;

    // With zero wait-states the lookup happens on the accept edge, so use the live address.
    assign w_look_addr = (r_state == StWait) ? r_addr : bus.i_addr;
    assign w_word      = (w_look_addr - BASE_ADDR) >> 2;
    assign w_fault     = (w_look_addr[1:0] != 2'b00) || (w_look_addr < BASE_ADDR) ||
                         (w_word >= 32'(DEPTH_WORDS));
    assign w_idx       = w_word[IdxW-1:0];

    assign w_load_word = (i_load_addr - BASE_ADDR) >> 2;
    assign w_load_ok   = (i_load_addr >= BASE_ADDR) && (w_load_word < 32'(DEPTH_WORDS));

    always_ff @(posedge clk) begin
        if (i_load_we && w_load_ok) begin
            r_mem[w_load_word[IdxW-1:0]] <= i_load_data;
        end
    end

    // Read uses pre-edge RAM contents, so a same-cycle load write returns old data.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_state <= StIdle;
            r_cnt   <= 4'd0;
            r_addr  <= 32'd0;
            r_valid <= 1'b0;
            r_fault <= 1'b0;
            r_instr <= NOP_INSTR;
        end else begin
            r_valid <= 1'b0;
            unique case (r_state)
                StIdle, StResp: begin
                    if (w_accept) begin
                        r_addr <= bus.i_addr;
                        if (WAIT_CYCLES == 0) begin
                            r_cnt   <= 4'd0;
                            r_state <= StResp;
                            r_valid <= 1'b1;
                            r_fault <= w_fault;
                            r_instr <= w_fault ? NOP_INSTR : r_mem[w_idx];
                        end else begin
                            r_cnt   <= 4'(WAIT_CYCLES);
                            r_state <= StWait;
                        end
                    end else begin
                        r_state <= StIdle;
                    end
                end
                StWait: begin
                    if (bus.i_flush) begin
                        r_cnt   <= 4'd0;
                        r_state <= StIdle;
                    end else if (r_cnt == 4'd1) begin
                        r_cnt   <= 4'd0;
                        r_state <= StResp;
                        r_valid <= 1'b1;
                        r_fault <= w_fault;
                        r_instr <= w_fault ? NOP_INSTR : r_mem[w_idx];
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end
endmodule
